// File: rtl/wb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback
// Purpose  : MIPS32 writeback stage; retires one instruction per accept, aligns
//            load data and drives the register-file write port plus ID bypass.
// Revision : 1.0  initial release
// ============================================================================
module wb_writeback #(
  parameter int RW = 5,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wreg_en,
  input  logic [RW-1:0] in_wreg_addr,
  input  logic [W-1:0]  in_alu_result,
  input  logic          in_is_load,
  input  logic [2:0]    in_load_type,
  input  logic [1:0]    in_byte_off,
  input  logic          dmem_rvalid,
  input  logic [W-1:0]  dmem_rdata,
  output logic          write_en,
  output logic [RW-1:0] write_addr,
  output logic [W-1:0]  write_data,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_addr,
  output logic [W-1:0]  fwd_data,
  output logic          misalign_err,
  output logic [31:0]   retired_count
);

  localparam logic [2:0] c_LW  = 3'd0;
  localparam logic [2:0] c_LH  = 3'd1;
  localparam logic [2:0] c_LHU = 3'd2;
  localparam logic [2:0] c_LB  = 3'd3;
  localparam logic [2:0] c_LBU = 3'd4;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_ld_wreg_en;
  logic [RW-1:0] r_ld_addr;
  logic [2:0]    r_ld_type;
  logic [1:0]    r_ld_off;
  logic          r_write_en;
  logic [RW-1:0] r_write_addr;
  logic [W-1:0]  r_write_data;
  logic          r_misalign;
  logic [31:0]   r_retired;

  logic          w_accept;
  logic          w_ld_legal;
  logic [W-1:0]  w_ld_data;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic          w_ld_write;

  assign in_ready = (r_state == S_IDLE) && rst;
  assign w_accept = in_valid && in_ready;

  // Lane selection is driven by the offset captured at accept time.
  assign w_half = r_ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign w_byte = dmem_rdata[{r_ld_off, 3'b000} +: 8];

  always_comb begin
    w_ld_legal = 1'b0;
    w_ld_data  = '0;
    case (r_ld_type)
      c_LW: begin
        w_ld_legal = (r_ld_off == 2'd0);
        w_ld_data  = dmem_rdata;
      end
      c_LH: begin
        w_ld_legal = ~r_ld_off[0];
        w_ld_data  = {{(W-16){w_half[15]}}, w_half};
      end
      c_LHU: begin
        w_ld_legal = ~r_ld_off[0];
        w_ld_data  = {{(W-16){1'b0}}, w_half};
      end
      c_LB: begin
        w_ld_legal = 1'b1;
        w_ld_data  = {{(W-8){w_byte[7]}}, w_byte};
      end
      c_LBU: begin
        w_ld_legal = 1'b1;
        w_ld_data  = {{(W-8){1'b0}}, w_byte};
      end
      default: begin
        w_ld_legal = 1'b0;
        w_ld_data  = '0;
      end
    endcase
  end

  assign w_ld_write = r_ld_wreg_en && (r_ld_addr != '0) && w_ld_legal;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept && in_is_load) w_state_next = S_WAIT_LOAD;
      S_WAIT_LOAD: if (dmem_rvalid)            w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_misalign   <= 1'b0;
      r_retired    <= '0;
      r_ld_wreg_en <= 1'b0;
      r_ld_addr    <= '0;
      r_ld_type    <= '0;
      r_ld_off     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_write_en <= 1'b0;
      r_misalign <= 1'b0;
      if (r_state == S_IDLE && w_accept) begin
        if (in_is_load) begin
          r_ld_wreg_en <= in_wreg_en;
          r_ld_addr    <= in_wreg_addr;
          r_ld_type    <= in_load_type;
          r_ld_off     <= in_byte_off;
        end else begin
          r_retired <= r_retired + 32'd1;
          // Address/data only move with a real write so they hold otherwise.
          if (in_wreg_en && in_wreg_addr != '0) begin
            r_write_en   <= 1'b1;
            r_write_addr <= in_wreg_addr;
            r_write_data <= in_alu_result;
          end
        end
      end else if (r_state == S_WAIT_LOAD && dmem_rvalid) begin
        r_retired  <= r_retired + 32'd1;
        r_misalign <= ~w_ld_legal;
        if (w_ld_write) begin
          r_write_en   <= 1'b1;
          r_write_addr <= r_ld_addr;
          r_write_data <= w_ld_data;
        end
      end
    end
  end

  assign write_en      = r_write_en;
  assign write_addr    = r_write_addr;
  assign write_data    = r_write_data;
  assign misalign_err  = r_misalign;
  assign retired_count = r_retired;
  assign fwd_valid     = r_write_en;
  assign fwd_addr      = r_write_addr;
  assign fwd_data      = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_writeback
// Purpose  : Self-checking bench for wb_writeback against a load/retire model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wreg_en, in_is_load;
  logic [4:0]  in_wreg_addr;
  logic [31:0] in_alu_result;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        write_en, fwd_valid, misalign_err;
  logic [4:0]  write_addr, fwd_addr;
  logic [31:0] write_data, fwd_data, retired_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_count = 0;
  logic [4:0]  last_addr = 0;
  logic [31:0] last_data = 0;

  wb_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg_en(in_wreg_en), .in_wreg_addr(in_wreg_addr),
    .in_alu_result(in_alu_result), .in_is_load(in_is_load),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load semantics computed with plain shifts and masks.
  function automatic void model_load(input int lt, input int off, input logic [31:0] rd,
                                     output bit legal, output logic [31:0] data);
    logic [31:0] h, b;
    legal = 0;
    data  = 0;
    if (lt == 0) begin
      legal = (off == 0);
      data  = rd;
    end else if (lt == 1 || lt == 2) begin
      legal = (off % 2 == 0);
      h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
      data = (lt == 1 && h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
    end else if (lt == 3 || lt == 4) begin
      legal = 1;
      b = (rd >> (8 * off)) & 32'h0000_00FF;
      data = (lt == 3 && b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    end
  endfunction

  task automatic test_reset();
    rst = 0; in_valid = 0; in_wreg_en = 0; in_wreg_addr = 0; in_alu_result = 0;
    in_is_load = 0; in_load_type = 0; in_byte_off = 0; dmem_rvalid = 0; dmem_rdata = 0;
    tick(); tick();
    exp_count = 0; last_addr = 0; last_data = 0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    checks++; if (write_en !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got we=%b err=%b want 0 0", write_en, misalign_err); end
    checks++; if (write_addr !== 5'd0 || write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0d/%h want 0/0", write_addr, write_data); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    rst = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu(input logic en, input logic [4:0] addr, input logic [31:0] val);
    bit exp_we;
    in_valid = 1; in_is_load = 0; in_wreg_en = en; in_wreg_addr = addr; in_alu_result = val;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    exp_we = en && addr != 0;
    exp_count++;
    if (exp_we) begin last_addr = addr; last_data = val; end
    checks++; if (write_en !== exp_we) begin errors++; $display("FAIL alu_we: got %b want %b", write_en, exp_we); end
    checks++; if (exp_we && (write_addr !== addr || write_data !== val)) begin errors++; $display("FAIL alu_write: got %0d/%h want %0d/%h", write_addr, write_data, addr, val); end
    checks++; if (fwd_valid !== write_en || fwd_addr !== write_addr || fwd_data !== write_data) begin errors++; $display("FAIL alu_fwd: got %b/%0d/%h want %b/%0d/%h", fwd_valid, fwd_addr, fwd_data, write_en, write_addr, write_data); end
    checks++; if (retired_count !== exp_count) begin errors++; $display("FAIL alu_count: got %0d want %0d", retired_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    in_is_load = 0; in_wreg_en = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_wreg_addr = 5'(i); in_alu_result = 32'hA000_0000 + 32'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
      tick();
      exp_count++; last_addr = 5'(i); last_data = 32'hA000_0000 + 32'(i);
      checks++; if (write_en !== 1'b1 || write_addr !== last_addr || write_data !== last_data) begin errors++; $display("FAIL b2b_write: got %b/%0d/%h want 1/%0d/%h", write_en, write_addr, write_data, last_addr, last_data); end
    end
    in_valid = 0;
    checks++; if (retired_count !== exp_count) begin errors++; $display("FAIL b2b_count: got %0d want %0d", retired_count, exp_count); end
  endtask

  task automatic test_load_case(input int lt, input int off, input logic [4:0] addr,
                                input logic en, input logic [31:0] rd, input int dly);
    bit          legal, exp_we;
    logic [31:0] exp_data;
    model_load(lt, off, rd, legal, exp_data);
    exp_we = en && addr != 0 && legal;
    in_valid = 1; in_is_load = 1; in_load_type = 3'(lt); in_byte_off = 2'(off);
    in_wreg_en = en; in_wreg_addr = addr; in_alu_result = $urandom;
    tick();
    in_valid = 0;
    checks++; if (write_en !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL load_accept: got we=%b rdy=%b want 0 0", write_en, in_ready); end
    for (int d = 0; d < dly; d++) begin
      tick();
      checks++; if (in_ready !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL load_wait: got rdy=%b we=%b want 0 0", in_ready, write_en); end
    end
    dmem_rvalid = 1; dmem_rdata = rd;
    tick();
    dmem_rvalid = 0; dmem_rdata = $urandom;
    exp_count++;
    if (exp_we) begin last_addr = addr; last_data = exp_data; end
    checks++; if (write_en !== exp_we || misalign_err !== !legal) begin errors++; $display("FAIL load_done: got we=%b err=%b want %b %b (type %0d off %0d)", write_en, misalign_err, exp_we, !legal, lt, off); end
    checks++; if (exp_we && (write_data !== exp_data || write_addr !== addr)) begin errors++; $display("FAIL load_data: got %0d/%h want %0d/%h (type %0d off %0d)", write_addr, write_data, addr, exp_data, lt, off); end
    checks++; if (retired_count !== exp_count || in_ready !== 1'b1) begin errors++; $display("FAIL load_count: got %0d rdy=%b want %0d 1", retired_count, in_ready, exp_count); end
    tick();
    checks++; if (write_en !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL load_pulse: got we=%b err=%b want 0 0", write_en, misalign_err); end
    checks++; if (write_addr !== last_addr || write_data !== last_data) begin errors++; $display("FAIL load_hold: got %0d/%h want %0d/%h", write_addr, write_data, last_addr, last_data); end
  endtask

  task automatic test_loads();
    test_load_case(3, 3, 5'd8, 1, 32'h80AA_BBCC, 3);
    test_load_case(4, 3, 5'd8, 1, 32'h80AA_BBCC, 3);
    test_load_case(1, 2, 5'd8, 1, 32'h80AA_BBCC, 3);
    test_load_case(2, 0, 5'd10, 1, 32'h1234_F00D, 1);
    test_load_case(0, 0, 5'd11, 1, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_misalign_and_zero();
    test_load_case(0, 2, 5'd9, 1, 32'h5555_AAAA, 2);
    test_load_case(1, 1, 5'd9, 1, 32'h5555_AAAA, 0);
    test_load_case(6, 0, 5'd9, 1, 32'h5555_AAAA, 1);
    test_load_case(0, 0, 5'd0, 1, 32'h7777_7777, 1);
    test_alu(1, 5'd0, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_abort();
    in_valid = 1; in_is_load = 1; in_load_type = 3'd0; in_byte_off = 2'd0;
    in_wreg_en = 1; in_wreg_addr = 5'd12;
    tick();
    in_valid = 0;
    tick();
    rst = 0;
    tick();
    rst = 1;
    exp_count = 0; last_addr = 0; last_data = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || retired_count !== 32'd0) begin errors++; $display("FAIL abort_state: got rdy=%b cnt=%0d want 1 0", in_ready, retired_count); end
    dmem_rvalid = 1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_rvalid = 0;
    checks++; if (write_en !== 1'b0 || misalign_err !== 1'b0 || retired_count !== 32'd0) begin errors++; $display("FAIL abort_stale: got we=%b err=%b cnt=%0d want 0 0 0", write_en, misalign_err, retired_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rvalid_collision();
    in_valid = 1; in_is_load = 1; in_load_type = 3'd4; in_byte_off = 2'd1;
    in_wreg_en = 1; in_wreg_addr = 5'd13;
    tick();
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'h0000_9900;
    in_valid = 1; in_is_load = 0; in_wreg_en = 1; in_wreg_addr = 5'd7; in_alu_result = 32'h0707_0707;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b want 0", in_ready); end
    tick();
    dmem_rvalid = 0;
    exp_count++;
    checks++; if (write_en !== 1'b1 || write_addr !== 5'd13 || write_data !== 32'h0000_0099) begin errors++; $display("FAIL coll_load: got %b/%0d/%h want 1/13/00000099", write_en, write_addr, write_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL coll_accept: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    exp_count++; last_addr = 5'd7; last_data = 32'h0707_0707;
    checks++; if (write_en !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h0707_0707) begin errors++; $display("FAIL coll_alu: got %b/%0d/%h want 1/7/07070707", write_en, write_addr, write_data); end
    checks++; if (retired_count !== exp_count) begin errors++; $display("FAIL coll_count: got %0d want %0d", retired_count, exp_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        test_alu(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
      else
        test_load_case($urandom_range(0, 7), $urandom_range(0, 3), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_alu(1, 5'd5, 32'h1234_5678);
    test_back_to_back();
    test_loads();
    test_misalign_and_zero();
    test_reset_abort();
    test_rvalid_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
